// File: rtl/omsp_gfx_refresh_lt24.sv
// omsp_gfx_refresh_lt24: display-side refresh engine. Opens an LT24 8080 write
// transaction per frame (MEMWR command, then display_size_i pixels), fetching
// each pixel from the backend through a request/ready handshake.
// Optional build macro OMSP_GFX_REFRESH_PREFETCH_EN: requests pixel n+1 while
// pixel n is being strobed and parks the reply in a one-entry holding register.
module omsp_gfx_refresh_lt24 #(
  parameter int unsigned SPIX_W    = 17,
  parameter int unsigned WR_CYCLES = 2,
  parameter logic [15:0] CMD_MEMWR = 16'h002C
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              refresh_start_i,
  input  logic [SPIX_W-1:0] display_size_i,
  input  logic [15:0]       refresh_data_i,
  input  logic              refresh_data_ready_i,
  output logic              refresh_active_o,
  output logic              refresh_data_request_o,
  output logic              refresh_done_o,
  output logic              lcd_cs_n_o,
  output logic              lcd_rs_o,
  output logic              lcd_wr_n_o,
  output logic [15:0]       lcd_d_o
);

  localparam int unsigned     PH_W    = 4;
  localparam logic [PH_W-1:0] PH_LOAD = PH_W'(WR_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, CMD_LO, CMD_HI, REQ, WAIT, DAT_LO, DAT_HI, DONE
  } state_t;

  state_t            state_q, state_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic [SPIX_W-1:0] cnt_q, cnt_d;
  logic              active_q, active_d;
  logic              req_q, req_d;
  logic              done_q, done_d;
  logic              cs_n_q, cs_n_d;
  logic              rs_q, rs_d;
  logic              wr_n_q, wr_n_d;
  logic [15:0]       dat_q, dat_d;

  logic              ph_last;
  logic              load_pix;
  logic [15:0]       load_val;
  logic              go_req;
  logic              go_done;

`ifdef OMSP_GFX_REFRESH_PREFETCH_EN
  logic              pend_q, pend_d;
  logic              hold_vld_q, hold_vld_d;
  logic [15:0]       hold_q, hold_d;
`endif

  assign ph_last = (ph_q == '0);

  // Next-state and next-output logic; outputs are registered from the *_d values
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    req_d    = 1'b0;
    done_d   = 1'b0;
    cs_n_d   = cs_n_q;
    rs_d     = rs_q;
    wr_n_d   = wr_n_q;
    dat_d    = dat_q;
    load_pix = 1'b0;
    load_val = refresh_data_i;
    go_req   = 1'b0;
    go_done  = 1'b0;
`ifdef OMSP_GFX_REFRESH_PREFETCH_EN
    pend_d     = pend_q;
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
`endif

    case (state_q)
      IDLE: begin
        if (refresh_start_i) begin
          state_d  = CMD_LO;
          cnt_d    = display_size_i;
          ph_d     = PH_LOAD;
          active_d = 1'b1;
          cs_n_d   = 1'b0;
          rs_d     = 1'b0;
          wr_n_d   = 1'b0;
          dat_d    = CMD_MEMWR;
        end
      end
      CMD_LO: begin
        if (ph_last) begin
          state_d = CMD_HI;
          ph_d    = PH_LOAD;
          wr_n_d  = 1'b1;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      CMD_HI: begin
        if (ph_last) begin
          if (cnt_q == '0) go_done = 1'b1;
          else             go_req  = 1'b1;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (refresh_data_ready_i) begin
          load_pix = 1'b1;
`ifdef OMSP_GFX_REFRESH_PREFETCH_EN
          pend_d = 1'b0;
`endif
        end
      end
      DAT_LO: begin
        if (ph_last) begin
          state_d = DAT_HI;
          ph_d    = PH_LOAD;
          wr_n_d  = 1'b1;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
`ifdef OMSP_GFX_REFRESH_PREFETCH_EN
        if (pend_q && refresh_data_ready_i) begin
          hold_d     = refresh_data_i;
          hold_vld_d = 1'b1;
          pend_d     = 1'b0;
        end
`endif
      end
      DAT_HI: begin
        if (ph_last) begin
          cnt_d = cnt_q - SPIX_W'(1);
          if (cnt_q == SPIX_W'(1)) begin
            go_done = 1'b1;
          end else begin
`ifdef OMSP_GFX_REFRESH_PREFETCH_EN
            if (hold_vld_q) begin
              load_pix   = 1'b1;
              load_val   = hold_q;
              hold_vld_d = 1'b0;
            end else if (pend_q && refresh_data_ready_i) begin
              load_pix = 1'b1;
              pend_d   = 1'b0;
            end else begin
              state_d = WAIT;
            end
`else
            go_req = 1'b1;
`endif
          end
        end else begin
          ph_d = ph_q - PH_W'(1);
`ifdef OMSP_GFX_REFRESH_PREFETCH_EN
          if (pend_q && refresh_data_ready_i) begin
            hold_d     = refresh_data_i;
            hold_vld_d = 1'b1;
            pend_d     = 1'b0;
          end
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Shared transition actions
    if (go_req) begin
      state_d = REQ;
      req_d   = 1'b1;
    end
    if (go_done) begin
      state_d  = DONE;
      done_d   = 1'b1;
      cs_n_d   = 1'b1;
      active_d = 1'b0;
      rs_d     = 1'b1;
    end
    if (load_pix) begin
      state_d = DAT_LO;
      ph_d    = PH_LOAD;
      wr_n_d  = 1'b0;
      rs_d    = 1'b1;
      dat_d   = load_val;
`ifdef OMSP_GFX_REFRESH_PREFETCH_EN
      if (cnt_d > SPIX_W'(1)) req_d = 1'b1;
`endif
    end
`ifdef OMSP_GFX_REFRESH_PREFETCH_EN
    if (req_d) pend_d = 1'b1;
`endif
  end

  // State, counters and registered outputs
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_q  <= IDLE;
      ph_q     <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      rs_q     <= 1'b1;
      wr_n_q   <= 1'b1;
      dat_q    <= '0;
    end else begin
      state_q  <= state_d;
      ph_q     <= ph_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      req_q    <= req_d;
      done_q   <= done_d;
      cs_n_q   <= cs_n_d;
      rs_q     <= rs_d;
      wr_n_q   <= wr_n_d;
      dat_q    <= dat_d;
    end
  end

`ifdef OMSP_GFX_REFRESH_PREFETCH_EN
  // Outstanding-request flag and one-entry pixel holding register
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      pend_q     <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      pend_q     <= pend_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
    end
  end
`endif

  assign refresh_active_o       = active_q;
  assign refresh_data_request_o = req_q;
  assign refresh_done_o         = done_q;
  assign lcd_cs_n_o             = cs_n_q;
  assign lcd_rs_o               = rs_q;
  assign lcd_wr_n_o             = wr_n_q;
  assign lcd_d_o                = dat_q;

endmodule

// File: tb/tb_omsp_gfx_refresh_lt24.sv
// Directed bench for omsp_gfx_refresh_lt24 (WR_CYCLES=2). Prefetch-specific
// timing is exercised when OMSP_GFX_REFRESH_PREFETCH_EN is defined.
`timescale 1ns/1ps
module tb_omsp_gfx_refresh_lt24;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic        refresh_start_i = 1'b0;
  logic [16:0] display_size_i = '0;
  logic [15:0] refresh_data_i = '0;
  logic        refresh_data_ready_i = 1'b0;
  logic        refresh_active_o;
  logic        refresh_data_request_o;
  logic        refresh_done_o;
  logic        lcd_cs_n_o;
  logic        lcd_rs_o;
  logic        lcd_wr_n_o;
  logic [15:0] lcd_d_o;

  omsp_gfx_refresh_lt24 dut (
    .mclk                  (mclk),
    .puc_rst               (puc_rst),
    .refresh_start_i       (refresh_start_i),
    .display_size_i        (display_size_i),
    .refresh_data_i        (refresh_data_i),
    .refresh_data_ready_i  (refresh_data_ready_i),
    .refresh_active_o      (refresh_active_o),
    .refresh_data_request_o(refresh_data_request_o),
    .refresh_done_o        (refresh_done_o),
    .lcd_cs_n_o            (lcd_cs_n_o),
    .lcd_rs_o              (lcd_rs_o),
    .lcd_wr_n_o            (lcd_wr_n_o),
    .lcd_d_o               (lcd_d_o)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  // Bus monitor: LCD write commits ({rs,d}), request and done pulses with cycle stamps
  logic [31:0] wr_cyc[$], wr_dat[$], req_cyc[$], done_cyc[$];
  logic prev_wr = 1'b1;
  initial forever begin
    @(negedge mclk);
    if (!prev_wr && lcd_wr_n_o) begin
      wr_cyc.push_back(32'(cyc));
      wr_dat.push_back({15'b0, lcd_rs_o, lcd_d_o});
    end
    prev_wr = lcd_wr_n_o;
    if (refresh_data_request_o) req_cyc.push_back(32'(cyc));
    if (refresh_done_o) done_cyc.push_back(32'(cyc));
  end

  // Backend model: answers request k after lat[k] cycles with dat[k]
  int          lat[16];
  logic [15:0] dat[16];
  int          bk_idx = 0;
  int          bk_wait = 0;
  int          stray_cyc = -1;
  initial forever begin
    @(negedge mclk);
    refresh_data_ready_i = 1'b0;
    if (bk_wait > 0) begin
      bk_wait--;
      if (bk_wait == 0) begin
        refresh_data_ready_i = 1'b1;
        refresh_data_i = dat[(bk_idx - 1) & 15];
      end
    end
    if (cyc == stray_cyc) begin
      refresh_data_ready_i = 1'b1;
      refresh_data_i = 16'hDEAD;
    end
    if (refresh_data_request_o) begin
      bk_wait = lat[bk_idx & 15];
      bk_idx++;
    end
  end

  task automatic new_frame();
    wr_cyc.delete(); wr_dat.delete(); req_cyc.delete(); done_cyc.delete();
    bk_idx = 0;
  endtask

  // Start pulse in cycle s; returns at the negedge of cycle s+1
  task automatic start_frame(input logic [16:0] size, output int s);
    @(negedge mclk);
    s = cyc;
    refresh_start_i = 1'b1;
    display_size_i  = size;
    @(negedge mclk);
    refresh_start_i = 1'b0;
    display_size_i  = 17'h1FFFF;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cyc.size() == 0 && n < budget) begin
      @(negedge mclk);
      n++;
    end
    if (done_cyc.size() == 0) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge mclk);
  endtask

  initial begin
    int s;
    logic bad_hold;
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int s;
    logic bad_hold;

    repeat (3) @(negedge mclk);
    puc_rst = 1'b0;
    @(negedge mclk);
    chk("rst_cs_n",   32'(lcd_cs_n_o), 32'd1);
    chk("rst_wr_n",   32'(lcd_wr_n_o), 32'd1);
    chk("rst_rs",     32'(lcd_rs_o), 32'd1);
    chk("rst_active", 32'(refresh_active_o), 32'd0);
    chk("rst_req",    32'(refresh_data_request_o), 32'd0);
    chk("rst_done",   32'(refresh_done_o), 32'd0);
    chk("rst_d",      32'(lcd_d_o), 32'd0);

    // Command-only frame (size 0)
    new_frame();
    start_frame(17'd0, s);
    chk("cmd_c1_cs_n",   32'(lcd_cs_n_o), 32'd0);
    chk("cmd_c1_rs",     32'(lcd_rs_o), 32'd0);
    chk("cmd_c1_d",      32'(lcd_d_o), 32'h002C);
    chk("cmd_c1_wr_n",   32'(lcd_wr_n_o), 32'd0);
    chk("cmd_c1_active", 32'(refresh_active_o), 32'd1);
    @(negedge mclk);
    chk("cmd_c2_wr_n",   32'(lcd_wr_n_o), 32'd0);
    @(negedge mclk);
    chk("cmd_c3_wr_n",   32'(lcd_wr_n_o), 32'd1);
    chk("cmd_c3_cs_n",   32'(lcd_cs_n_o), 32'd0);
    @(negedge mclk);
    chk("cmd_c4_wr_n",   32'(lcd_wr_n_o), 32'd1);
    chk("cmd_c4_done",   32'(refresh_done_o), 32'd0);
    @(negedge mclk);
    chk("cmd_c5_done",   32'(refresh_done_o), 32'd1);
    chk("cmd_c5_cs_n",   32'(lcd_cs_n_o), 32'd1);
    chk("cmd_c5_active", 32'(refresh_active_o), 32'd0);
    @(negedge mclk);
    chk("cmd_c6_done",   32'(refresh_done_o), 32'd0);
    chk("cmd_nreq",      32'(req_cyc.size()), 32'd0);

`ifndef OMSP_GFX_REFRESH_PREFETCH_EN
    // Three-pixel frame, L=1
    new_frame();
    lat[0] = 1; lat[1] = 1; lat[2] = 1;
    dat[0] = 16'h1111; dat[1] = 16'h2222; dat[2] = 16'h3333;
    start_frame(17'd3, s);
    wait_done(100);
    chk("p3_nreq",  32'(req_cyc.size()), 32'd3);
    chk("p3_req0",  qat(req_cyc, 0), 32'(s + 5));
    chk("p3_req1",  qat(req_cyc, 1), 32'(s + 11));
    chk("p3_req2",  qat(req_cyc, 2), 32'(s + 17));
    chk("p3_nwr",   32'(wr_dat.size()), 32'd4);
    chk("p3_wr0",   qat(wr_dat, 0), 32'h0000_002C);
    chk("p3_wr1",   qat(wr_dat, 1), 32'h0001_1111);
    chk("p3_wr2",   qat(wr_dat, 2), 32'h0001_2222);
    chk("p3_wr3",   qat(wr_dat, 3), 32'h0001_3333);
    chk("p3_wrc0",  qat(wr_cyc, 0), 32'(s + 3));
    chk("p3_wrc1",  qat(wr_cyc, 1), 32'(s + 9));
    chk("p3_wrc2",  qat(wr_cyc, 2), 32'(s + 15));
    chk("p3_wrc3",  qat(wr_cyc, 3), 32'(s + 21));
    chk("p3_done",  qat(done_cyc, 0), 32'(s + 23));

    // Backpressure: pixel 2 arrives 10 cycles after its request
    new_frame();
    lat[0] = 1; lat[1] = 10; lat[2] = 1;
    dat[0] = 16'hA1A1; dat[1] = 16'hA2A2; dat[2] = 16'hA3A3;
    start_frame(17'd3, s);
    bad_hold = 1'b0;
    for (int c = 0; c < 21; c++) begin
      @(negedge mclk);
      if (cyc >= s + 11 && cyc <= s + 21 && (lcd_wr_n_o !== 1'b1 || lcd_d_o !== 16'hA1A1))
        bad_hold = 1'b1;
    end
    chk("bp_hold", 32'(bad_hold), 32'd0);
    wait_done(100);
    chk("bp_nreq",  32'(req_cyc.size()), 32'd3);
    chk("bp_req1",  qat(req_cyc, 1), 32'(s + 11));
    chk("bp_req2",  qat(req_cyc, 2), 32'(s + 26));
    chk("bp_wr2",   qat(wr_dat, 2), 32'h0001_A2A2);
    chk("bp_wrc2",  qat(wr_cyc, 2), 32'(s + 24));
    chk("bp_done",  qat(done_cyc, 0), 32'(s + 32));

    // Ignored events: start pulse during DAT_LO, ready pulse during DAT_HI
    new_frame();
    lat[0] = 1; lat[1] = 1;
    dat[0] = 16'hB1B1; dat[1] = 16'hB2B2;
    start_frame(17'd2, s);
    stray_cyc = s + 9;
    wait_cyc(s + 7);
    refresh_start_i = 1'b1;
    display_size_i  = 17'd7;
    @(negedge mclk);
    refresh_start_i = 1'b0;
    wait_cyc(s + 10);
    chk("ign_d_hold", 32'(lcd_d_o), 32'hB1B1);
    wait_done(100);
    stray_cyc = -1;
    repeat (10) @(negedge mclk);
    chk("ign_nreq",   32'(req_cyc.size()), 32'd2);
    chk("ign_nwr",    32'(wr_dat.size()), 32'd3);
    chk("ign_wr1",    qat(wr_dat, 1), 32'h0001_B1B1);
    chk("ign_wr2",    qat(wr_dat, 2), 32'h0001_B2B2);
    chk("ign_done",   qat(done_cyc, 0), 32'(s + 17));
    chk("ign_ndone",  32'(done_cyc.size()), 32'd1);
    chk("ign_idle",   32'(lcd_cs_n_o), 32'd1);
`else
    // Prefetch: L=2, size 4 -> back-to-back 4-cycle pixels
    new_frame();
    for (int i = 0; i < 4; i++) begin
      lat[i] = 2;
      dat[i] = 16'(16'hD1D1 + 16'(i) * 16'h0101);
    end
    start_frame(17'd4, s);
    wait_done(100);
    chk("pf_nreq",  32'(req_cyc.size()), 32'd4);
    chk("pf_req0",  qat(req_cyc, 0), 32'(s + 5));
    chk("pf_req1",  qat(req_cyc, 1), 32'(s + 8));
    chk("pf_req2",  qat(req_cyc, 2), 32'(s + 12));
    chk("pf_req3",  qat(req_cyc, 3), 32'(s + 16));
    chk("pf_wrc1",  qat(wr_cyc, 1), 32'(s + 10));
    chk("pf_wrc2",  qat(wr_cyc, 2), 32'(s + 14));
    chk("pf_wrc3",  qat(wr_cyc, 3), 32'(s + 18));
    chk("pf_wrc4",  qat(wr_cyc, 4), 32'(s + 22));
    chk("pf_wr1",   qat(wr_dat, 1), 32'h0001_D1D1);
    chk("pf_wr4",   qat(wr_dat, 4), 32'h0001_D4D4);
    chk("pf_done",  qat(done_cyc, 0), 32'(s + 24));
`endif

    // Reset mid-frame (after three pixels, cnt=5), then a normal one-pixel frame
    new_frame();
    for (int i = 0; i < 8; i++) begin
      lat[i] = 1;
      dat[i] = 16'(16'hC000 + 16'(i));
    end
    start_frame(17'd8, s);
    wait_cyc(s + 23);
    puc_rst = 1'b1;
    @(negedge mclk);
    chk("mrst_cs_n",   32'(lcd_cs_n_o), 32'd1);
    chk("mrst_wr_n",   32'(lcd_wr_n_o), 32'd1);
    chk("mrst_active", 32'(refresh_active_o), 32'd0);
    chk("mrst_req",    32'(refresh_data_request_o), 32'd0);
    chk("mrst_d",      32'(lcd_d_o), 32'd0);
    repeat (2) @(negedge mclk);
    puc_rst = 1'b0;
    repeat (15) @(negedge mclk);
    chk("mrst_ndone",  32'(done_cyc.size()), 32'd0);
    chk("mrst_idle",   32'(refresh_active_o), 32'd0);

    new_frame();
    lat[0] = 1;
    dat[0] = 16'hC1C1;
    start_frame(17'd1, s);
    wait_done(100);
    chk("post_nreq",  32'(req_cyc.size()), 32'd1);
    chk("post_wr0",   qat(wr_dat, 0), 32'h0000_002C);
    chk("post_wr1",   qat(wr_dat, 1), 32'h0001_C1C1);
    chk("post_done",  qat(done_cyc, 0), 32'(s + 11));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
